// File: rtl/sakebi_pkg.sv
// sakebi_pkg
// Shared definitions for the sakebi RX frame controller:
//   - rx_state_t       : controller state encoding (IDLE / RECV / LAST)
//   - TUSER_*          : bit positions inside the 3-bit close status (TUSER)
//   - *_DEF            : default minimum/maximum frame length and idle timeout
//   - LEN_W / LEN_MAX  : width and saturation value of the frame length counter
//   - mac_byte()       : picks destination-address byte 1..6 (byte 1 = MSB)
// Optional feature macro used by the importing files: SAKEBI_RXCTRL_MACFILT_EN
package sakebi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_LAST = 2'd2
    } rx_state_t;

    localparam int TUSER_W       = 3;
    localparam int TUSER_LEN_ERR = 0;
    localparam int TUSER_OVF     = 1;
    localparam int TUSER_ADDR    = 2;

    localparam int MIN_LEN_DEF      = 64;
    localparam int MAX_LEN_DEF      = 1518;
    localparam int IDLE_TIMEOUT_DEF = 16;

    localparam int LEN_W     = 11;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam int MAC_BYTES = 6;

    // Destination address arrives MSB first, so frame position 1 is addr[47:40].
    function automatic logic [7:0] mac_byte(input logic [47:0] addr,
                                            input logic [LEN_W-1:0] pos);
        logic [7:0] b;
        b = 8'h00;
        case (pos)
            11'd1:   b = addr[47:40];
            11'd2:   b = addr[39:32];
            11'd3:   b = addr[31:24];
            11'd4:   b = addr[23:16];
            11'd5:   b = addr[15:8];
            11'd6:   b = addr[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sakebi_rx_gap_timer.sv
// sakebi_rx_gap_timer
// Counts idle cycles between received bytes and flags when the line has been
// silent long enough to close a frame.
// Ports:
//   i_axis_ACLK     clock
//   i_axis_ARESETn  asynchronous active-low reset
//   clr             synchronous clear (highest priority)
//   en              count one more silent cycle
//   tc              terminal-count pulse: en is high while count == LIMIT-1
module sakebi_rx_gap_timer #(
    parameter int LIMIT = 16,
    localparam int CW = $clog2(LIMIT + 1)
) (
    input  logic i_axis_ACLK,
    input  logic i_axis_ARESETn,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] cnt;

    assign tc = en && (cnt == CW'(LIMIT - 1));

    // Holds at the terminal value so a stalled close does not wrap the count.
    always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sakebi_rx_frame_ctrl.sv
// sakebi_rx_frame_ctrl
// Turns the unframed byte strobe of an RMII receiver into an AXI-Stream frame.
// A byte is held in H until the next byte (or the idle timeout) proves whether
// it is the last one, then moves to the output register O with TLAST/TUSER.
// Ports:
//   i_axis_ACLK / i_axis_ARESETn     clock, asynchronous active-low reset
//   i_s_axis_TVALID/TDATA, o_s_axis_TREADY   input bytes (TREADY always 1)
//   o_m_axis_TVALID/TDATA/TLAST/TUSER, i_m_axis_TREADY   output stream
//       TUSER on TLAST: [0] length error, [1] overflow, [2] address mismatch
//   o_frame_cnt   frames closed (wraps)
//   o_err_cnt     frames closed with TUSER!=0 plus bytes dropped in LAST (wraps)
//   i_mac_addr    station address, present only with SAKEBI_RXCTRL_MACFILT_EN
// Macro SAKEBI_RXCTRL_MACFILT_EN enables destination-address filtering.
module sakebi_rx_frame_ctrl
    import sakebi_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
    parameter int MIN_LEN      = MIN_LEN_DEF,
    parameter int MAX_LEN      = MAX_LEN_DEF
) (
    input  logic                  i_axis_ACLK,
    input  logic                  i_axis_ARESETn,
    input  logic                  i_s_axis_TVALID,
    input  logic [DATA_WIDTH-1:0] i_s_axis_TDATA,
    output logic                  o_s_axis_TREADY,
    output logic                  o_m_axis_TVALID,
    input  logic                  i_m_axis_TREADY,
    output logic [DATA_WIDTH-1:0] o_m_axis_TDATA,
    output logic                  o_m_axis_TLAST,
    output logic [TUSER_W-1:0]    o_m_axis_TUSER,
    output logic [15:0]           o_frame_cnt,
    output logic [15:0]           o_err_cnt
`ifdef SAKEBI_RXCTRL_MACFILT_EN
    ,
    input  logic [47:0]           i_mac_addr
`endif
);

    localparam logic [LEN_W-1:0] MIN_LEN_C = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

    rx_state_t             state;
    logic [DATA_WIDTH-1:0] h_data;
    logic                  h_valid;
    logic [LEN_W-1:0]      len_q;
    logic                  ovf_q;
    logic                  gap_tc;
    logic                  o_free;
    logic                  do_close;
    logic                  len_err;
    logic                  addr_err;
    logic [LEN_W-1:0]      len_inc;
    logic [TUSER_W-1:0]    close_user;
    logic                  close_err;
    logic                  last_drop;

    assign o_s_axis_TREADY = 1'b1;

    // O can take a new beat when empty or when its current beat leaves this cycle.
    assign o_free   = !o_m_axis_TVALID || i_m_axis_TREADY;
    assign len_inc  = (len_q == LEN_MAX) ? len_q : len_q + LEN_W'(1);
    assign len_err  = (len_q < MIN_LEN_C) || (len_q > MAX_LEN_C);
    assign do_close = h_valid && o_free &&
                      ((state == ST_RECV && gap_tc) || state == ST_LAST);
    assign close_err = do_close && (close_user != '0);
    assign last_drop = (state == ST_LAST) && i_s_axis_TVALID;

`ifdef SAKEBI_RXCTRL_MACFILT_EN
    logic mac_ok;
    logic bc_ok;
    assign addr_err = !(mac_ok || bc_ok) || (len_q < LEN_W'(MAC_BYTES));
`else
    assign addr_err = 1'b0;
`endif

    always_comb begin
        close_user                = '0;
        close_user[TUSER_LEN_ERR] = len_err;
        close_user[TUSER_OVF]     = ovf_q;
        close_user[TUSER_ADDR]    = addr_err;
    end

    sakebi_rx_gap_timer #(
        .LIMIT(IDLE_TIMEOUT)
    ) u_gap_timer (
        .i_axis_ACLK   (i_axis_ACLK),
        .i_axis_ARESETn(i_axis_ARESETn),
        .clr           ((state != ST_RECV) || i_s_axis_TVALID),
        .en            ((state == ST_RECV) && !i_s_axis_TVALID),
        .tc            (gap_tc)
    );

    // Frame FSM with the H/O datapath. The close load sits after the case so
    // it overrides the per-state defaults in the cycle it happens.
    always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) begin
            state           <= ST_IDLE;
            h_data          <= '0;
            h_valid         <= 1'b0;
            len_q           <= '0;
            ovf_q           <= 1'b0;
            o_m_axis_TVALID <= 1'b0;
            o_m_axis_TDATA  <= '0;
            o_m_axis_TLAST  <= 1'b0;
            o_m_axis_TUSER  <= '0;
            o_frame_cnt     <= '0;
            o_err_cnt       <= '0;
`ifdef SAKEBI_RXCTRL_MACFILT_EN
            mac_ok          <= 1'b0;
            bc_ok           <= 1'b0;
`endif
        end else begin
            if (o_m_axis_TVALID && i_m_axis_TREADY) begin
                o_m_axis_TVALID <= 1'b0;
            end

            unique case (state)
                ST_IDLE: begin
                    if (i_s_axis_TVALID) begin
                        h_data  <= i_s_axis_TDATA;
                        h_valid <= 1'b1;
                        len_q   <= LEN_W'(1);
                        ovf_q   <= 1'b0;
                        state   <= ST_RECV;
`ifdef SAKEBI_RXCTRL_MACFILT_EN
                        mac_ok  <= (i_s_axis_TDATA[7:0] == mac_byte(i_mac_addr, LEN_W'(1)));
                        bc_ok   <= (i_s_axis_TDATA[7:0] == 8'hFF);
`endif
                    end
                end
                ST_RECV: begin
                    if (i_s_axis_TVALID) begin
                        if (o_free) begin
                            o_m_axis_TDATA  <= h_data;
                            o_m_axis_TLAST  <= 1'b0;
                            o_m_axis_TUSER  <= '0;
                            o_m_axis_TVALID <= 1'b1;
                            h_data          <= i_s_axis_TDATA;
                            len_q           <= len_inc;
`ifdef SAKEBI_RXCTRL_MACFILT_EN
                            if (len_inc <= LEN_W'(MAC_BYTES)) begin
                                mac_ok <= mac_ok &&
                                          (i_s_axis_TDATA[7:0] == mac_byte(i_mac_addr, len_inc));
                                bc_ok  <= bc_ok && (i_s_axis_TDATA[7:0] == 8'hFF);
                            end
`endif
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end else if (gap_tc && !o_free) begin
                        state <= ST_LAST;
                    end
                end
                ST_LAST: begin
                    // Safety exit should H ever be empty here; normally do_close leaves.
                    if (!h_valid) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (do_close) begin
                o_m_axis_TDATA  <= h_data;
                o_m_axis_TLAST  <= 1'b1;
                o_m_axis_TUSER  <= close_user;
                o_m_axis_TVALID <= 1'b1;
                h_valid         <= 1'b0;
                state           <= ST_IDLE;
            end

            o_frame_cnt <= o_frame_cnt + 16'(do_close);
            o_err_cnt   <= o_err_cnt + 16'(close_err) + 16'(last_drop);
        end
    end

endmodule
